// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and line constants shared by the uart_xcvr files.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   MIN_DIV       = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO; data_o is the head whenever empty_o is low.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART with runtime baud divisor, RX FIFO and sticky error flags.
// Build option: define UART_PARITY_EN to add a parity bit on both TX and RX frames.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int RX_DEPTH   = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic                          tx_start,
    input  logic [DATA_W-1:0]             tx_data,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          ser_tx,
    input  logic                          ser_rx,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(RX_DEPTH):0]     rx_count,
    output logic                          rx_overrun,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    input  logic                          err_clear
);
    // state  | meaning
    // IDLE   | TX waits for tx_start; RX waits for a 1->0 edge
    // START  | start bit; RX re-checks the line at mid-bit to reject glitches
    // DATA   | DATA_W data bits, LSB first
    // PARITY | parity bit (UART_PARITY_EN builds only)
    // STOP   | stop bit(s); RX samples only the first
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
    localparam logic          PAR_SENSE = 1'(PARITY_ODD);
`endif

    uart_state_e       tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic              tx_go_q, tx_go_d, tx_stop_q, tx_stop_d;
    logic              tx_ser_q, tx_ser_d, tx_done_q, tx_done_d;
    logic [DIV_W-1:0]  tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
    logic [DIV_W-1:0]  rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [1:0]        sync_q;
    logic              rx_s, rx_prev_q, rx_push_q, rx_push_d;
    logic              ovr_q, ferr_q, ferr_set, ovr_set, fifo_full, fifo_empty;
    logic              tx_tick, rx_tick;
`ifdef UART_PARITY_EN
    logic              tx_par_q, tx_par_d, perr_q, perr_set;
`endif

    assign tx_tick = (tx_cnt_q == '0);
    assign rx_tick = (rx_cnt_q == '0);
    assign rx_s    = sync_q[1];

    // TX: the request is latched first and the start bit goes out one edge later.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_go_d    = tx_go_q;
        tx_div_d   = tx_div_q;
        tx_cnt_d   = tx_tick ? tx_cnt_q : tx_cnt_q - DIV_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_sh_d    = tx_sh_q;
        tx_ser_d   = tx_ser_q;
        tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            ST_IDLE: begin
                if (tx_go_q) begin
                    tx_go_d    = 1'b0;
                    tx_state_d = ST_START;
                    tx_ser_d   = ~UART_IDLE_LVL;
                    tx_cnt_d   = tx_div_q - DIV_W'(1);
                end else if (tx_start) begin
                    tx_go_d  = 1'b1;
                    tx_div_d = cfg_div;
                    tx_sh_d  = tx_data;
`ifdef UART_PARITY_EN
                    tx_par_d = (^tx_data) ^ PAR_SENSE;
`endif
                end
            end
            ST_START: if (tx_tick) begin
                tx_state_d = ST_DATA;
                tx_ser_d   = tx_sh_q[0];
                tx_bit_d   = '0;
                tx_cnt_d   = tx_div_q - DIV_W'(1);
            end
            ST_DATA: if (tx_tick) begin
                tx_cnt_d = tx_div_q - DIV_W'(1);
                if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    tx_state_d = ST_PARITY;
                    tx_ser_d   = tx_par_q;
`else
                    tx_state_d = ST_STOP;
                    tx_ser_d   = UART_IDLE_LVL;
                    tx_stop_d  = 1'b0;
`endif
                end else begin
                    tx_bit_d = tx_bit_q + BW'(1);
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_ser_d = tx_sh_q[1];
                end
            end
            ST_PARITY: if (tx_tick) begin
                tx_state_d = ST_STOP;
                tx_ser_d   = UART_IDLE_LVL;
                tx_stop_d  = 1'b0;
                tx_cnt_d   = tx_div_q - DIV_W'(1);
            end
            ST_STOP: if (tx_tick) begin
                if (tx_stop_q == LAST_STOP) begin
                    tx_state_d = ST_IDLE;
                    tx_done_d  = 1'b1;
                end else begin
                    tx_stop_d = 1'b1;
                    tx_cnt_d  = tx_div_q - DIV_W'(1);
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // RX: first sample lands at floor(div/2) after the edge, then every div cycles.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_cnt_d   = rx_tick ? rx_cnt_q : rx_cnt_q - DIV_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push_d  = 1'b0;
        ferr_set   = 1'b0;
`ifdef UART_PARITY_EN
        perr_set   = 1'b0;
`endif
        case (rx_state_q)
            ST_IDLE: if (rx_prev_q && !rx_s) begin
                rx_state_d = ST_START;
                rx_div_d   = cfg_div;
                rx_cnt_d   = (cfg_div >> 1) - DIV_W'(1);
            end
            ST_START: if (rx_tick) begin
                rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                rx_bit_d   = '0;
                rx_cnt_d   = rx_div_q - DIV_W'(1);
            end
            ST_DATA: if (rx_tick) begin
                rx_sh_d  = {rx_s, rx_sh_q[DATA_W-1:1]};
                rx_cnt_d = rx_div_q - DIV_W'(1);
                rx_bit_d = rx_bit_q + BW'(1);
`ifdef UART_PARITY_EN
                if (rx_bit_q == LAST_BIT) rx_state_d = ST_PARITY;
`else
                if (rx_bit_q == LAST_BIT) rx_state_d = ST_STOP;
`endif
            end
            ST_PARITY: if (rx_tick) begin
`ifdef UART_PARITY_EN
                perr_set = (rx_s != ((^rx_sh_q) ^ PAR_SENSE));
`endif
                rx_state_d = ST_STOP;
                rx_cnt_d   = rx_div_q - DIV_W'(1);
            end
            ST_STOP: if (rx_tick) begin
                rx_state_d = ST_IDLE;
                rx_push_d  = rx_s;
                ferr_set   = !rx_s;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // A full FIFO only accepts the push if the host pops in the same cycle.
    assign ovr_set = rx_push_q && fifo_full && !rx_ready;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_state_q <= ST_IDLE;
            tx_go_q    <= 1'b0;
            tx_div_q   <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_sh_q    <= '0;
            tx_ser_q   <= UART_IDLE_LVL;
            tx_done_q  <= 1'b0;
            rx_state_q <= ST_IDLE;
            rx_div_q   <= '0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_push_q  <= 1'b0;
            sync_q     <= {2{UART_IDLE_LVL}};
            rx_prev_q  <= UART_IDLE_LVL;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_go_q    <= tx_go_d;
            tx_div_q   <= tx_div_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_sh_q    <= tx_sh_d;
            tx_ser_q   <= tx_ser_d;
            tx_done_q  <= tx_done_d;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_push_q  <= rx_push_d;
            sync_q     <= {sync_q[0], ser_rx};
            rx_prev_q  <= rx_s;
            ovr_q      <= ovr_set  | (ovr_q  & ~err_clear);
            ferr_q     <= ferr_set | (ferr_q & ~err_clear);
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
            perr_q     <= perr_set | (perr_q & ~err_clear);
`endif
        end
    end

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (DATA_W)
    ) u_rx_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (rx_push_q),
        .pop_i   (rx_ready),
        .data_i  (rx_sh_q),
        .data_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (rx_count)
    );

    assign rx_valid     = !fifo_empty;
    assign tx_busy      = (tx_state_q != ST_IDLE);
    assign tx_done      = tx_done_q;
    assign ser_tx       = tx_ser_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: scoreboard bench for uart_xcvr (TX waveform, loopback, overrun, errors, reset).
// Define UART_PARITY_EN for both bench and RTL to cover the parity build.
`timescale 1ns/1ps
module tb_uart_xcvr;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int RX_DEPTH = 4;
    localparam int CW = $clog2(RX_DEPTH) + 1;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_W + PAR_BITS + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DIV_W-1:0]  div = 16'd16;
    logic              tx_start = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_busy, tx_done, ser_tx, ser_rx;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready = 1'b0;
    logic [CW-1:0]     rx_count;
    logic              rx_overrun, rx_frame_err, rx_parity_err;
    logic              err_clear = 1'b0;
    logic              loop_en = 1'b0;
    logic              ser_drv = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;
    assign ser_rx = loop_en ? ser_tx : ser_drv;

    uart_xcvr #(.DATA_W(DATA_W), .DIV_W(DIV_W), .RX_DEPTH(RX_DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_div(div),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .ser_tx(ser_tx), .ser_rx(ser_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .err_clear(err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame bits in wire order: start, data LSB first, [parity], stop.
    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_W-1:0] d,
                                                      input logic stop, input logic pflip);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[DATA_W:1] = d;
`ifdef UART_PARITY_EN
        f[DATA_W+1] = (^d) ^ pflip;
`else
        f[0] = pflip & 1'b0;
`endif
        f[FRAME_BITS-1] = stop;
        return f;
    endfunction

    task automatic drive_frame(input logic [DATA_W-1:0] d, input logic stop, input logic pflip);
        logic [FRAME_BITS-1:0] f;
        f = frame_of(d, stop, pflip);
        for (int i = 0; i < FRAME_BITS; i++) begin
            ser_drv = f[i];
            repeat (int'(div)) @(negedge clk);
        end
        ser_drv = 1'b1;
        repeat (int'(div)) @(negedge clk);
    endtask

    task automatic start_tx(input logic [DATA_W-1:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_tx_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < (FRAME_BITS + 2) * int'(div) && !seen; i++) begin
            @(negedge clk);
            seen = tx_done;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // Pops the FIFO head and compares it against the oldest scoreboard entry.
    task automatic pop_check(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < (FRAME_BITS + 2) * int'(div) && !seen; i++) begin
            if (rx_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(seen), 32'd1);
        if (seen && exp_q.size() > 0) begin
            chk(tag, 32'(rx_data), 32'(exp_q.pop_front()));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FRAME_BITS-1:0] f;

        repeat (3) @(negedge clk);
        chk("rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // TX waveform, 0x3D at div 16: busy and start bit appear one edge after the latch edge.
        f = frame_of(8'h3D, 1'b1, 1'b0);
        tx_data  = 8'h3D;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("tx_busy_latch", 32'(tx_busy), 32'd0);
        for (int k = 0; k < FRAME_BITS * 16; k++) begin
            @(negedge clk);
            chk($sformatf("tx_bit%0d_c%0d", k / 16, k % 16), 32'(ser_tx), 32'(f[k / 16]));
            if (k == 0) chk("tx_busy_rise", 32'(tx_busy), 32'd1);
            if (k == FRAME_BITS * 16 - 1) chk("tx_done_early", 32'(tx_done), 32'd0);
        end
        @(negedge clk);
        chk("tx_done_pulse", 32'(tx_done), 32'd1);
        chk("tx_busy_fall", 32'(tx_busy), 32'd0);
        @(negedge clk);
        chk("tx_done_once", 32'(tx_done), 32'd0);

        // Loopback with a back-to-back start in the tx_done cycle and an ignored start while busy.
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        start_tx(8'h0F);
        exp_q.push_back(8'h0F);
        wait_tx_done("lb_done0");
        start_tx(8'h3D);
        exp_q.push_back(8'h3D);
        repeat (3 * int'(div)) @(negedge clk);
        chk("lb_busy", 32'(tx_busy), 32'd1);
        start_tx(8'hFF);
        wait_tx_done("lb_done1");
        repeat (4 * int'(div)) @(negedge clk);
        chk("lb_start_ignored", 32'(tx_busy), 32'd0);
        chk("lb_count", 32'(rx_count), 32'd2);
        pop_check("lb_rx0");
        pop_check("lb_rx1");
        chk("lb_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);
        loop_en = 1'b0;

        // Overrun: five frames, no pops; the fifth is dropped.
        div = 16'd8;
        for (int i = 0; i < 5; i++) begin
            drive_frame(DATA_W'(8'h11 * (i + 1)), 1'b1, 1'b0);
            if (i < RX_DEPTH) exp_q.push_back(DATA_W'(8'h11 * (i + 1)));
        end
        repeat (4) @(negedge clk);
        chk("ovr_count", 32'(rx_count), 32'd4);
        chk("ovr_flag", 32'(rx_overrun), 32'd1);
        chk("ovr_head", 32'(rx_data), 32'h11);
        clear_errs();
        chk("ovr_cleared", 32'(rx_overrun), 32'd0);
        for (int i = 0; i < RX_DEPTH; i++) pop_check($sformatf("ovr_rx%0d", i));
        chk("ovr_drained", 32'(rx_count), 32'd0);

        // Frame error: bad stop bit discards the word; the next frame is fine.
        div = 16'd16;
        drive_frame(8'hA5, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("ferr_flag", 32'(rx_frame_err), 32'd1);
        chk("ferr_count", 32'(rx_count), 32'd0);
        drive_frame(8'h5A, 1'b1, 1'b0);
        exp_q.push_back(8'h5A);
        pop_check("ferr_next");
        chk("ferr_no_ovr", 32'(rx_overrun), 32'd0);
        clear_errs();
        chk("ferr_cleared", 32'(rx_frame_err), 32'd0);

        // False start: 3-cycle glitch is rejected at the mid-bit check.
        ser_drv = 1'b0;
        repeat (3) @(negedge clk);
        ser_drv = 1'b1;
        repeat (2 * int'(div)) @(negedge clk);
        chk("fs_count", 32'(rx_count), 32'd0);
        chk("fs_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);
        drive_frame(8'hC3, 1'b1, 1'b0);
        exp_q.push_back(8'hC3);
        pop_check("fs_next");

`ifdef UART_PARITY_EN
        drive_frame(8'h3D, 1'b1, 1'b1);
        exp_q.push_back(8'h3D);
        repeat (4) @(negedge clk);
        chk("perr_flag", 32'(rx_parity_err), 32'd1);
        pop_check("perr_word");
        clear_errs();
        chk("perr_cleared", 32'(rx_parity_err), 32'd0);
`endif

        // Reset mid-frame on both paths, with a word sitting in the FIFO.
        drive_frame(8'h77, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("rstm_pre_count", 32'(rx_count), 32'd1);
        loop_en = 1'b1;
        start_tx(8'h3D);
        repeat (5 * int'(div)) @(negedge clk);
        chk("rstm_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstm_ser_tx", 32'(ser_tx), 32'd1);
        chk("rstm_tx_busy", 32'(tx_busy), 32'd0);
        chk("rstm_count", 32'(rx_count), 32'd0);
        chk("rstm_valid", 32'(rx_valid), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_tx(8'h81);
        exp_q.push_back(8'h81);
        wait_tx_done("rstm_done");
        pop_check("rstm_next");
        loop_en = 1'b0;

        repeat (4) @(negedge clk);
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("end_count", 32'(rx_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
